// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: trap/jump redirects, sequential advance,
// and next-PC prediction from a direct-mapped branch target buffer.
module pc_gen #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int unsigned     BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            if_ready_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic [XLEN-1:0] jump_src_pc_i,
    input  logic            trap_en_i,
    input  logic [XLEN-1:0] trap_addr_i,
    output logic [XLEN-1:0] pc_addr_o,
    output logic            pc_valid_o,
    output logic            pred_taken_o,
    output logic            misalign_o
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;
    localparam int unsigned TGT_W = XLEN - 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [TGT_W-1:0]       btb_tgt_q [BTB_ENTRIES];

    logic             btb_we;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [TGT_W-1:0] wr_tgt;
    logic [IDX-1:0]   lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             btb_hit;
    logic [XLEN-1:0]  trap_vec;
    logic             jump_misaligned;
    logic             unused_addr_bits;

    // Lookup reads the registered pc and the pre-write BTB contents.
    assign lkp_idx = pc_q[IDX+1:2];
    assign lkp_tag = pc_q[XLEN-1:IDX+2];
    assign btb_hit = btb_valid_q[lkp_idx] && (btb_tag_q[lkp_idx] == lkp_tag);

    assign trap_vec        = {trap_addr_i[XLEN-1:2], 2'b00};
    assign jump_misaligned = |jump_addr_i[1:0];
    assign wr_idx          = jump_src_pc_i[IDX+1:2];
    assign wr_tag          = jump_src_pc_i[XLEN-1:IDX+2];
    assign wr_tgt          = jump_addr_i[XLEN-1:2];
    assign unused_addr_bits = ^{trap_addr_i[1:0], jump_src_pc_i[1:0]};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        btb_we      = 1'b0;
        btb_valid_d = btb_valid_q;

        unique case (state_q)
            BOOT, RUN: begin
                if (trap_en_i) begin
                    pc_d    = trap_vec;
                    state_d = RUN;
                end else if (jump_en_i && !jump_misaligned) begin
                    pc_d    = jump_addr_i;
                    btb_we  = 1'b1;
                    state_d = RUN;
                end else if (jump_en_i) begin
                    state_d = FAULT;
                end else begin
                    state_d = RUN;
                    if (state_q == RUN && if_ready_i && !stall_i) begin
                        pc_d = btb_hit ? {btb_tgt_q[lkp_idx], 2'b00} : pc_q + XLEN'(4);
                    end
                end
            end
            FAULT: begin
                if (trap_en_i) begin
                    pc_d    = trap_vec;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        if (btb_we) begin
            btb_valid_d[wr_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            btb_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    // NOTE: tag/target storage has no reset; the cleared valid bits make stale contents harmless.
    always_ff @(posedge clk) begin
        if (rst && btb_we) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= wr_tgt;
        end
    end

    assign pc_addr_o    = pc_q;
    assign pc_valid_o   = (state_q == RUN);
    assign misalign_o   = (state_q == FAULT);
    assign pred_taken_o = pc_valid_o && btb_hit;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a driver queues the outputs expected in each cycle,
// a monitor pops and compares them on the falling edge.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        if_ready_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [31:0] jump_src_pc_i;
    logic        trap_en_i;
    logic [31:0] trap_addr_i;
    logic [31:0] pc_addr_o;
    logic        pc_valid_o;
    logic        pred_taken_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] pc;
        logic        pr;
        logic        mi;
    } exp_t;

    exp_t exp_q[$];

    pc_gen #(
        .XLEN       (32),
        .RESET_VEC  (32'h8000_0000),
        .BTB_ENTRIES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .if_ready_i   (if_ready_i),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .jump_src_pc_i(jump_src_pc_i),
        .trap_en_i    (trap_en_i),
        .trap_addr_i  (trap_addr_i),
        .pc_addr_o    (pc_addr_o),
        .pc_valid_o   (pc_valid_o),
        .pred_taken_o (pred_taken_o),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h ({valid,pred,misalign,pc})", name, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {29'd0, pc_valid_o, pred_taken_o, misalign_o, pc_addr_o},
                  {29'd0, e.v, e.pr, e.mi, e.pc});
        end
    end

    // Drive this cycle's inputs and queue the outputs the DUT must show in this same cycle.
    task automatic step(input string name, input logic r, input logic st, input logic rd,
                        input logic je, input logic [31:0] ja, input logic [31:0] js,
                        input logic te, input logic [31:0] ta,
                        input logic ev, input logic [31:0] ep, input logic epr, input logic em);
        exp_t e;
        rst           = r;
        stall_i       = st;
        if_ready_i    = rd;
        jump_en_i     = je;
        jump_addr_i   = ja;
        jump_src_pc_i = js;
        trap_en_i     = te;
        trap_addr_i   = ta;
        e.name = name; e.v = ev; e.pc = ep; e.pr = epr; e.mi = em;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; if_ready_i = 1'b1; jump_en_i = 1'b0;
        jump_addr_i = '0; jump_src_pc_i = '0; trap_en_i = 1'b0; trap_addr_i = '0;
        @(posedge clk);
        #1;
        //    name                rst st rd je  jump_addr     jump_src    te  trap_addr     v  pc            pr mi
        step("rst_a",             0, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        0, 32'h8000_0000, 0, 0);
        step("rst_b",             0, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        0, 32'h8000_0000, 0, 0);
        step("boot",              1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        0, 32'h8000_0000, 0, 0);
        step("seq_0",             1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h8000_0000, 0, 0);
        step("seq_4",             1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h8000_0004, 0, 0);
        step("seq_8",             1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h10,       1, 32'h8000_0008, 0, 0);
        step("stall_0",           1, 1, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h10,        0, 0);
        step("stall_1",           1, 1, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h10,        0, 0);
        step("stall_2",           1, 1, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h10,        0, 0);
        step("bp_0",              1, 0, 0, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h10,        0, 0);
        step("bp_1",              1, 0, 0, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h10,        0, 0);
        step("stall_jump",        1, 1, 0, 1, 32'h40,       32'h10,     0, 32'h0,        1, 32'h10,        0, 0);
        step("jump_tgt_40",       1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h40,        0, 0);
        step("seq_44",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h44,        0, 0);
        step("trap_and_jump",     1, 0, 1, 1, 32'h40,       32'h48,     1, 32'h100,      1, 32'h48,        0, 0);
        step("trap_prio",         1, 0, 1, 0, 32'h0,        32'h0,      1, 32'hFFFF_FFFC, 1, 32'h100,      0, 0);
        step("wrap_pre",          1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0);
        step("wrap_0",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h0,         0, 0);
        step("seq_04",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h4,         0, 0);
        step("seq_08",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h8,         0, 0);
        step("seq_0c",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'hC,         0, 0);
        step("hit_10",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h10,        1, 0);
        step("pred_tgt_40",       1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h40,        0, 0);
        step("seq_44b",           1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h44,        0, 0);
        step("no_write_48",       1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h48,        0, 0);
        step("train_20_200",      1, 0, 1, 1, 32'h200,      32'h20,     0, 32'h0,        1, 32'h4C,        0, 0);
        step("jump_tgt_200",      1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h14,       1, 32'h200,       0, 0);
        step("seq_14",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h14,        0, 0);
        step("seq_18",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h18,        0, 0);
        step("seq_1c",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h1C,        0, 0);
        step("hit_20",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h20,        1, 0);
        step("pred_tgt_200",      1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h200,       0, 0);
        step("seq_204",           1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h3C,       1, 32'h204,       0, 0);
        step("at_3c",             1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h3C,        0, 0);
        step("alias_40_miss",     1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h40,        0, 0);
        step("misalign_jump",     1, 0, 1, 1, 32'h42,       32'h44,     0, 32'h0,        1, 32'h44,        0, 0);
        step("fault_0",           1, 0, 1, 1, 32'h80,       32'h80,     0, 32'h0,        0, 32'h44,        0, 1);
        step("fault_1",           1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h103,      0, 32'h44,        0, 1);
        step("trap_exit",         1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h100,       0, 0);
        step("seq_104",           1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h44,       1, 32'h104,       0, 0);
        step("no_write_44",       1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h20,       1, 32'h44,        0, 0);
        step("hit_20_kept",       1, 0, 1, 1, 32'h202,      32'h20,     0, 32'h0,        1, 32'h20,        1, 0);
        step("fault_pred_gated",  0, 0, 1, 0, 32'h0,        32'h0,      1, 32'h300,      0, 32'h20,        0, 1);
        step("rst_in_fault",      1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        0, 32'h8000_0000, 0, 0);
        step("boot_exit",         1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h10,       1, 32'h8000_0000, 0, 0);
        step("cleared_10",        1, 0, 1, 0, 32'h0,        32'h0,      1, 32'h20,       1, 32'h10,        0, 0);
        step("cleared_20",        1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h20,        0, 0);
        step("seq_24",            1, 0, 1, 0, 32'h0,        32'h0,      0, 32'h0,        1, 32'h24,        0, 0);
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It drives a fetch address with a valid/ready handshake to instruction fetch and holds on pipeline stall. Redirects are prioritised: trap first, then jump. Next-PC prediction uses a small direct-mapped branch target buffer (BTB) trained by resolved jumps. A misaligned jump target parks the block in a fault state until a trap redirect arrives.

## Interface
- XLEN, 32: address width.
- RESET_VEC, 32'h0: pc_addr_o value out of reset.
- BTB_ENTRIES, 8: BTB depth, power of two ≥ 2; IDX = log2(BTB_ENTRIES).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- stall_i  in  1  pipeline stall; blocks sequential/predicted advance.
- if_ready_i  in  1  fetch accepts pc_addr_o this cycle.
- jump_en_i  in  1  resolved jump/branch-taken redirect.
- jump_addr_i  in  XLEN  redirect target.
- jump_src_pc_i  in  XLEN  PC of the jumping instruction (BTB training).
- trap_en_i  in  1  trap redirect.
- trap_addr_i  in  XLEN  trap vector, bits [1:0] forced to 0 internally.
- pc_addr_o  out  XLEN  current fetch address.
- pc_valid_o  out  1  pc_addr_o is a fetch request.
- pred_taken_o  out  1  BTB hit for pc_addr_o (qualified by pc_valid_o).
- misalign_o  out  1  high while in FAULT.

## Operation
- FSM states: BOOT, RUN, FAULT.
- Reset: pc_addr_o=RESET_VEC, pc_valid_o=0, misalign_o=0, state BOOT, all BTB valid bits cleared.
- BOOT: next cycle go to RUN, pc unchanged, except that a trap or jump redirect is applied using the same rules as RUN.
- RUN, priority per cycle, highest first:
  1. trap_en_i: pc←{trap_addr_i[XLEN-1:2],2'b00}, stay RUN.
  2. jump_en_i with jump_addr_i[1:0]==0: pc←jump_addr_i, train BTB.
  3. jump_en_i with jump_addr_i[1:0]!=0: go to FAULT, pc holds, no BTB write.
  4. pc_valid_o && if_ready_i && !stall_i: pc←BTB hit ? btb_target : pc+4.
  5. Otherwise hold.
- Redirects ignore stall_i and if_ready_i.
- pc_valid_o=1 only in RUN. misalign_o=1 only in FAULT.
- FAULT: only trap_en_i has effect (load trap vector, go to RUN). jump_en_i is ignored.
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC advances to 0.
- BTB:
  - Entry = {valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:2]}.
  - Lookup index = pc_addr_o[IDX+1:2]. Hit = valid && tag match.
  - Lookup is combinational on the registered pc.
  - Write on training: index/tag from jump_src_pc_i, target from jump_addr_i. Overwrites unconditionally.
  - A write and a lookup of the same index in the same cycle: the lookup sees the old contents; the write is visible from the next cycle.
- Reset at any time, including mid-FAULT or during a BTB write, takes precedence over everything.

## Timing
- Every pc update is registered: a redirect asserted in cycle N makes pc_addr_o equal the target in cycle N+1.
- First valid fetch: the second cycle after rst deasserts (BOOT lasts one cycle).
- Sequential throughput: one address per cycle while if_ready_i=1 and stall_i=0.
- pred_taken_o is combinational from pc_addr_o and the BTB, settled in the same cycle as pc_addr_o.
- FAULT entry: misalign_o=1 and pc_valid_o=0 from cycle N+1.
- FAULT exit: trap in cycle M gives RUN with the vector on pc_addr_o in cycle M+1.

## Test plan
- Reset with RESET_VEC=32'h8000_0000, if_ready_i=1 held: BOOT cycle valid=0, then 8000_0000, 8000_0004, 8000_0008 on consecutive cycles.
- Stall and backpressure: stall_i=1 or if_ready_i=0 for 3 cycles at pc 0x10 -> pc holds 0x10 and valid stays 1. jump_en_i to 0x40 during the stall -> pc=0x40 next cycle.
- Simultaneous events: trap_en_i (0x100) together with jump_en_i (0x40) -> pc=0x100 and no BTB write. Wrap test: pc 32'hFFFF_FFFC advances to 0.
- BTB train and hit: jump from src 0x20 to 0x200 -> on a later sequential pass, pc reaches 0x20 with pred_taken_o=1 and the next pc is 0x200. A different tag at the same index (0x20+4·BTB_ENTRIES) -> miss, next pc = pc+4.
- Misaligned jump to 0x42 -> misalign_o=1, valid=0, and further jump_en_i is ignored. trap_en_i with trap_addr_i=0x103 -> pc=0x100, RUN, misalign_o=0.
- Reset mid-operation: rst=0 while in FAULT with BTB populated -> pc=RESET_VEC, previously trained PCs now miss.
